fifo_rr_reader: RTL and testbench



---
 rtl/fifo_rr_reader.sv | 119 +++++++++++
 tb/tb_fifo_rr_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_reader.sv
// Round-robin reader for a bank of first-word-fall-through FIFOs; serializes heads onto one valid/ready stream.
// Optional word-drop timeout on a stalled output is enabled with `define READER_TIMEOUT_EN.
module fifo_rr_reader #(
    parameter int width   = 16,
    parameter int depth   = 8,
    parameter int devices = 4,
    parameter int TIMEOUT = 64,
    localparam int SW     = $clog2(devices)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [devices-1:0]         pndng_i,
    input  logic [devices*width-1:0]   dato_i,
    output logic [devices-1:0]         pop_o,
    output logic [width-1:0]           dato_o,
    output logic [SW-1:0]              src_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       drop_o
);

    // FIFO depth does not size anything here; kept so the bank and reader share one parameter set.
    localparam int unused_depth = depth;

    typedef enum logic [1:0] {IDLE, POP, HOLD} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] ptr, grant, grant_nxt, ptr_nxt;
    logic          found;
    logic          timeout_hit;

`ifdef READER_TIMEOUT_EN
    logic [15:0] cnt;
    logic        drop_r;
    assign timeout_hit = (cnt == 16'(TIMEOUT - 1)) && !ready_i;
    assign drop_o      = drop_r;
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
    assign drop_o      = 1'b0;
`endif

    // First pending FIFO scanning from ptr, wrapping modulo devices.
    always_comb begin
        found     = 1'b0;
        grant_nxt = grant;
        for (int i = 0; i < devices; i++) begin
            int idx;
            idx = (int'(ptr) + i) % devices;
            if (!found && pndng_i[idx]) begin
                found     = 1'b1;
                grant_nxt = SW'(idx);
            end
        end
    end

    assign ptr_nxt = (grant == SW'(devices - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop_o     = '0;
        case (state)
            IDLE: if (found) state_nxt = POP;
            POP: begin
                // A FIFO emptied behind our back is simply skipped; arbitration restarts.
                if (pndng_i[grant] && rst) pop_o[grant] = 1'b1;
                state_nxt = pndng_i[grant] ? HOLD : IDLE;
            end
            HOLD: if (ready_i || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr     <= '0;
            grant   <= '0;
            dato_o  <= '0;
            src_o   <= '0;
            valid_o <= 1'b0;
`ifdef READER_TIMEOUT_EN
            cnt     <= '0;
            drop_r  <= 1'b0;
`endif
        end else begin
`ifdef READER_TIMEOUT_EN
            drop_r <= 1'b0;
`endif
            case (state)
                IDLE: if (found) grant <= grant_nxt;
                POP: if (pndng_i[grant]) begin
                    dato_o  <= dato_i[grant*width +: width];
                    src_o   <= grant;
                    valid_o <= 1'b1;
                    ptr     <= ptr_nxt;
`ifdef READER_TIMEOUT_EN
                    cnt     <= '0;
`endif
                end
                HOLD: begin
                    if (ready_i) valid_o <= 1'b0;
`ifdef READER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        valid_o <= 1'b0;
                        drop_r  <= 1'b1;
                    end else cnt <= cnt + 16'd1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_reader.sv
// Directed bench for fifo_rr_reader: a small FIFO bank model feeds the reader, expected words are hand-derived.
module tb_fifo_rr_reader;

    localparam int W = 16;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [D-1:0]   pndng_i;
    logic [D*W-1:0] dato_i;
    logic [D-1:0]   pop_o;
    logic [W-1:0]   dato_o;
    logic [1:0]     src_o;
    logic           valid_o;
    logic           ready_i;
    logic           drop_o;

    logic [W-1:0] mem [D][8];
    int           rd [D];
    int           wr [D];
    logic [D-1:0] mask;

    int checks = 0;
    int errors = 0;

    fifo_rr_reader #(.width(W), .depth(8), .devices(D), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .pndng_i(pndng_i), .dato_i(dato_i), .pop_o(pop_o),
        .dato_o(dato_o), .src_o(src_o), .valid_o(valid_o), .ready_i(ready_i), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < D; k++) begin
            pndng_i[k]        = (wr[k] != rd[k]) && !mask[k];
            dato_i[k*W +: W]  = mem[k][rd[k] % 8];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < D; k++)
            if (pop_o[k]) rd[k] <= rd[k] + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [W-1:0] d);
        mem[k][wr[k] % 8] = d;
        wr[k] = wr[k] + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the next valid word, then checks it.
    task automatic expect_word(input string tag, input logic [W-1:0] d, input logic [1:0] s);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid_o) break;
        end
        check({tag, "_valid"}, valid_o, 1);
        check({tag, "_dato"}, dato_o, d);
        check({tag, "_src"}, src_o, s);
    endtask

    initial begin
        for (int k = 0; k < D; k++) begin
            rd[k] = 0;
            wr[k] = 0;
        end
        mask    = '0;
        rst     = 1'b0;
        ready_i = 1'b0;
        push(0, 16'h10); push(1, 16'h11); push(2, 16'h12); push(3, 16'h13);

        // reset held with all FIFOs pending
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_pop", pop_o, 0);
            check("rst_valid", valid_o, 0);
            check("rst_dato", dato_o, 0);
            check("rst_src", src_o, 0);
            check("rst_drop", drop_o, 0);
        end
        rst = 1'b1;
        tick();
        check("first_pop", pop_o, 4'b0001);
        tick();
        check("first_valid", valid_o, 1);
        check("first_dato", dato_o, 16'h10);
        check("first_src", src_o, 0);
        check("first_nopop", pop_o, 0);

        ready_i = 1'b1;
        expect_word("drain1", 16'h11, 1);
        expect_word("drain2", 16'h12, 2);
        expect_word("drain3", 16'h13, 3);
        tick(); tick();

        // round robin, pointer wraps 3 -> 0
        push(0, 16'hA); push(0, 16'hB); push(3, 16'hC); push(3, 16'hD);
        expect_word("rr_a", 16'hA, 0);
        expect_word("rr_c", 16'hC, 3);
        expect_word("rr_b", 16'hB, 0);
        expect_word("rr_d", 16'hD, 3);
        tick();

        // single word latency
        push(2, 16'h6);
        tick();
        check("single_pop", pop_o, 4'b0100);
        tick();
        check("single_valid", valid_o, 1);
        check("single_dato", dato_o, 16'h6);
        check("single_src", src_o, 2);
        tick();
        check("single_ack", valid_o, 0);

        // backpressure
        ready_i = 1'b0;
        push(2, 16'h6);
        tick();
        check("bp_pop", pop_o, 4'b0100);
        tick();
        check("bp_valid", valid_o, 1);
        push(1, 16'h7);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", {pop_o, drop_o, valid_o, src_o, dato_o}, {4'b0000, 1'b0, 1'b1, 2'd2, 16'h6});
        end
        ready_i = 1'b1;
        tick();
        check("bp_ack", valid_o, 0);
        expect_word("bp_next", 16'h7, 1);
        tick();

        // withdrawn request during POP
        push(1, 16'h9);
        tick();
        mask[1] = 1'b1;
        #1;
        check("wd_nopop", pop_o, 0);
        tick();
        check("wd_novalid", valid_o, 0);
        check("wd_rd", rd[1], wr[1] - 1);
        push(3, 16'h5);
        expect_word("wd_rearb", 16'h5, 3);
        mask[1] = 1'b0;
        expect_word("wd_resume", 16'h9, 1);
        tick();

`ifdef READER_TIMEOUT_EN
        ready_i = 1'b0;
        push(0, 16'h21); push(2, 16'h22);
        tick();
        tick();
        check("to_valid", valid_o, 1);
        check("to_dato", dato_o, 16'h22);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("to_wait", {drop_o, valid_o}, 2'b01);
        end
        tick();
        check("to_drop", {drop_o, valid_o}, 2'b10);
        tick();
        check("to_pulse", drop_o, 0);
        ready_i = 1'b1;
        expect_word("to_next", 16'h21, 0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
